dfd_te_msg_sched: RTL

- Sequencer that turns one trace message (up to MAX_FIELDS fields) into an MSEO/MDO byte stream.
- Issues one field per cycle to the combinational MSEO field encoder, which sits outside this block. Drives that encoder's is_var and is_last controls.
- Collects the variable-length encoder results in a byte buffer. Emits fixed OUT_BYTES-wide beats to the trace sink with valid/ready backpressure.
- Sits between the TE message builder and the trace sink/funnel.

---
 rtl/dfd_te_pkg.sv | 26 ++
 rtl/dfd_te_byte_packer.sv | 129 ++++++++++++
 rtl/dfd_te_msg_sched_chk.sv | 36 +++
 rtl/dfd_te_msg_sched.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dfd_te_pkg.sv
// Shared types and constants for the trace-encoder message scheduler.
//   TE_ENC_BYTES         : worst-case encoder output bytes for one field
//   te_msg_sched_state_e : scheduler FSM states
//   te_field_t           : one latched message field (payload, bit length, variable flag)
// The struct widths follow the package defaults; the scheduler parameters are
// expected to keep DATA_WIDTH equal to TE_DATA_WIDTH.
package dfd_te_pkg;

    localparam int TE_DATA_WIDTH = 64;
    localparam int TE_MDO_BITS   = 6;
    localparam int TE_ENC_BYTES  = (TE_DATA_WIDTH + TE_MDO_BITS - 1) / TE_MDO_BITS;
    localparam int TE_LEN_W      = $clog2(TE_DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } te_msg_sched_state_e;

    typedef struct packed {
        logic [TE_DATA_WIDTH-1:0] data;
        logic [TE_LEN_W-1:0]      len;
        logic                     is_var;
    } te_field_t;

endpackage

// File: rtl/dfd_te_byte_packer.sv
// Byte packing buffer between the MSEO encoder and the trace sink.
//   app_en_i/app_last_i/app_data_i/app_len_i : append request from the scheduler
//   out_valid/out_ready/out_data/out_be/out_eom : fixed-width beat interface
//   count_o, space_ok_o, mark_valid_o, pop_eom_o : status back to the scheduler
// Holds at most one end-of-message marker: the scheduler never appends bytes of a
// new message until the previous one has fully drained.
module dfd_te_byte_packer
    import dfd_te_pkg::*;
#(
    parameter int ENC_BYTES = TE_ENC_BYTES,
    parameter int OUT_BYTES = 8,
    parameter int BUF_BYTES = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               app_en_i,
    input  logic                               app_last_i,
    input  logic [ENC_BYTES*8-1:0]             app_data_i,
    input  logic [$clog2(ENC_BYTES):0]         app_len_i,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [OUT_BYTES*8-1:0]             out_data,
    output logic [OUT_BYTES-1:0]               out_be,
    output logic                               out_eom,
    output logic [$clog2(BUF_BYTES+1)-1:0]     count_o,
    output logic                               space_ok_o,
    output logic                               mark_valid_o,
    output logic                               pop_eom_o
);

    localparam int CNT_W = $clog2(BUF_BYTES + 1);

    logic [BUF_BYTES*8-1:0] buf_q, buf_d, app_wide_s;
    logic [ENC_BYTES*8-1:0] app_masked_s;
    logic [CNT_W-1:0]       count_q, count_d, mark_pos_q, mark_pos_d;
    logic [CNT_W-1:0]       beat_n_s, pop_n_s, base_s;
    logic                   mark_valid_q, mark_valid_d, mark_in_beat_s, pop_s;

    function automatic logic [OUT_BYTES-1:0] be_mask(input logic [CNT_W-1:0] n);
        logic [OUT_BYTES-1:0] m;
        for (int i = 0; i < OUT_BYTES; i++) begin
            m[i] = (CNT_W'(i) < n);
        end
        return m;
    endfunction

    // Beat decode: a beat stops at the end-of-message marker so it never spans messages.
    always_comb begin
        mark_in_beat_s = mark_valid_q && (mark_pos_q <= CNT_W'(OUT_BYTES));
        if (mark_in_beat_s) begin
            beat_n_s = mark_pos_q;
        end else begin
            beat_n_s = CNT_W'(OUT_BYTES);
        end
        out_valid = (count_q >= CNT_W'(OUT_BYTES)) || (mark_valid_q && (count_q != CNT_W'(0)));
        if (out_valid) begin
            out_be  = be_mask(beat_n_s);
            out_eom = mark_in_beat_s;
        end else begin
            out_be  = {OUT_BYTES{1'b0}};
            out_eom = 1'b0;
        end
        out_data = buf_q[OUT_BYTES*8-1:0];
        pop_s    = out_valid && out_ready;
        if (pop_s) begin
            pop_n_s = beat_n_s;
        end else begin
            pop_n_s = CNT_W'(0);
        end
    end

    // Next buffer state: shift out the popped beat, then append at the post-pop tail.
    always_comb begin
        for (int i = 0; i < ENC_BYTES; i++) begin
            if (i < int'(app_len_i)) begin
                app_masked_s[i*8 +: 8] = app_data_i[i*8 +: 8];
            end else begin
                app_masked_s[i*8 +: 8] = 8'h00;
            end
        end
        base_s     = count_q - pop_n_s;
        app_wide_s = {{((BUF_BYTES - ENC_BYTES) * 8){1'b0}}, app_masked_s};
        app_wide_s = app_wide_s << {base_s, 3'b000};
        if (app_en_i) begin
            buf_d   = (buf_q >> {pop_n_s, 3'b000}) | app_wide_s;
            count_d = base_s + CNT_W'(app_len_i);
        end else begin
            buf_d   = buf_q >> {pop_n_s, 3'b000};
            count_d = base_s;
        end
        mark_valid_d = mark_valid_q;
        mark_pos_d   = mark_pos_q - pop_n_s;
        if (pop_s && out_eom) begin
            mark_valid_d = 1'b0;
            mark_pos_d   = CNT_W'(0);
        end else begin
            mark_valid_d = mark_valid_q;
        end
        // A message that produced no bytes gets no marker; the scheduler sees that directly.
        if (app_en_i && app_last_i && (count_d != CNT_W'(0))) begin
            mark_valid_d = 1'b1;
            mark_pos_d   = count_d;
        end else begin
            mark_pos_d   = mark_pos_d;
        end
    end

    // Buffer, fill count and marker registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q        <= {(BUF_BYTES*8){1'b0}};
            count_q      <= CNT_W'(0);
            mark_pos_q   <= CNT_W'(0);
            mark_valid_q <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            count_q      <= count_d;
            mark_pos_q   <= mark_pos_d;
            mark_valid_q <= mark_valid_d;
        end
    end

    // Free-space check uses the registered count so a same-cycle pop is never relied on.
    assign space_ok_o   = (CNT_W'(BUF_BYTES) - count_q) >= CNT_W'(ENC_BYTES);
    assign count_o      = count_q;
    assign mark_valid_o = mark_valid_q;
    assign pop_eom_o    = pop_s && out_eom;

endmodule

// File: rtl/dfd_te_msg_sched_chk.sv
// Property checker for the message scheduler: fill bound, encoder length bound,
// contiguous byte enables, no descriptor accept during ISSUE, static sizing.
module dfd_te_msg_sched_chk
    import dfd_te_pkg::*;
#(
    parameter int DATA_WIDTH = TE_DATA_WIDTH,
    parameter int MDO_BITS   = TE_MDO_BITS,
    parameter int ENC_BYTES  = TE_ENC_BYTES,
    parameter int OUT_BYTES  = 8,
    parameter int BUF_BYTES  = 32
) (
    input logic                           clk,
    input logic                           reset_n,
    input logic [$clog2(BUF_BYTES+1)-1:0] count,
    input logic [$clog2(ENC_BYTES):0]     enc_len_bytes,
    input logic [OUT_BYTES-1:0]           out_be,
    input te_msg_sched_state_e            state,
    input logic                           msg_valid,
    input logic                           msg_ready
);

    localparam int CNT_W = $clog2(BUF_BYTES + 1);
    localparam int EB_W  = $clog2(ENC_BYTES) + 1;

    a_sizing: assert property (@(posedge clk)
        (ENC_BYTES == (DATA_WIDTH + MDO_BITS - 1) / MDO_BITS) && (BUF_BYTES >= ENC_BYTES + OUT_BYTES));
    a_count: assert property (@(posedge clk) disable iff (!reset_n)
        count <= CNT_W'(BUF_BYTES));
    a_enc_len: assert property (@(posedge clk) disable iff (!reset_n)
        (state != ISSUE) || (enc_len_bytes <= EB_W'(ENC_BYTES)));
    a_be_contig: assert property (@(posedge clk) disable iff (!reset_n)
        ((out_be + OUT_BYTES'(1)) & out_be) == OUT_BYTES'(0));
    a_no_accept_issue: assert property (@(posedge clk) disable iff (!reset_n)
        !(state == ISSUE && msg_valid && msg_ready));

endmodule

// File: rtl/dfd_te_msg_sched.sv
// Trace message scheduler: accepts one message descriptor, issues its fields one
// per cycle to the external combinational MSEO encoder, and streams the encoded
// bytes as fixed-width beats through the byte packer.
//   msg_*        : descriptor handshake and payloads from the message builder
//   enc_*        : field drive to / encoded bytes from the MSEO encoder
//   out_*        : beat stream to the trace sink (valid/ready)
//   busy         : message in flight or bytes still buffered
module dfd_te_msg_sched
    import dfd_te_pkg::*;
#(
    parameter int DATA_WIDTH = TE_DATA_WIDTH,
    parameter int MDO_BITS   = TE_MDO_BITS,
    parameter int ENC_BYTES  = TE_ENC_BYTES,
    parameter int MAX_FIELDS = 4,
    parameter int OUT_BYTES  = 8,
    parameter int BUF_BYTES  = 32
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          msg_valid,
    output logic                                          msg_ready,
    input  logic [$clog2(MAX_FIELDS):0]                   msg_num_fields,
    input  logic [MAX_FIELDS*DATA_WIDTH-1:0]              msg_data,
    input  logic [MAX_FIELDS*($clog2(DATA_WIDTH)+1)-1:0]  msg_len,
    input  logic [MAX_FIELDS-1:0]                         msg_is_var,
    output logic [DATA_WIDTH-1:0]                         enc_data_in,
    output logic [$clog2(DATA_WIDTH):0]                   enc_data_len,
    output logic                                          enc_is_var,
    output logic                                          enc_is_last,
    input  logic [ENC_BYTES*8-1:0]                        enc_data_out,
    input  logic [$clog2(ENC_BYTES):0]                    enc_len_bytes,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [OUT_BYTES*8-1:0]                        out_data,
    output logic [OUT_BYTES-1:0]                          out_be,
    output logic                                          out_eom,
    output logic                                          busy
);

    localparam int LEN_W = $clog2(DATA_WIDTH) + 1;
    localparam int NF_W  = $clog2(MAX_FIELDS) + 1;
    localparam int IDX_W = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;
    localparam int CNT_W = $clog2(BUF_BYTES + 1);

    te_msg_sched_state_e state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NF_W-1:0]     num_q, num_d;
    te_field_t           fields_q [MAX_FIELDS];
    te_field_t           fields_d [MAX_FIELDS];
    logic                rdy_en_q;
    logic                fire_s, last_s, space_ok_s, mark_valid_s, pop_eom_s;
    logic [CNT_W-1:0]    count_s;

    // Next-state, encoder drive and descriptor handshake.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        num_d        = num_q;
        fields_d     = fields_q;
        msg_ready    = 1'b0;
        fire_s       = 1'b0;
        last_s       = 1'b0;
        enc_data_in  = {DATA_WIDTH{1'b0}};
        enc_data_len = {LEN_W{1'b0}};
        enc_is_var   = 1'b0;
        enc_is_last  = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low for the first cycle out of reset.
                msg_ready = rdy_en_q;
            end
            ISSUE: begin
                last_s       = (NF_W'(idx_q) == (num_q - NF_W'(1)));
                enc_data_in  = fields_q[idx_q].data;
                enc_data_len = fields_q[idx_q].len;
                enc_is_var   = fields_q[idx_q].is_var;
                enc_is_last  = last_s;
                if (space_ok_s) begin
                    fire_s = 1'b1;
                    if (last_s) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (!mark_valid_s) begin
                    // Message produced no bytes at all.
                    state_d = IDLE;
                end else if (pop_eom_s) begin
                    msg_ready = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (msg_valid && msg_ready) begin
            for (int i = 0; i < MAX_FIELDS; i++) begin
                fields_d[i].data   = msg_data[i*DATA_WIDTH +: DATA_WIDTH];
                fields_d[i].len    = msg_len[i*LEN_W +: LEN_W];
                fields_d[i].is_var = msg_is_var[i];
            end
            num_d = msg_num_fields;
            idx_d = IDX_W'(0);
            if (msg_num_fields == NF_W'(0)) begin
                state_d = IDLE;
            end else begin
                state_d = ISSUE;
            end
        end else begin
            num_d = num_q;
        end
    end

    // FSM, field index and latched descriptor registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= IDX_W'(0);
            num_q    <= NF_W'(0);
            fields_q <= '{default: '0};
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            fields_q <= fields_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign busy = (state_q != IDLE) || (count_s != CNT_W'(0));

    dfd_te_byte_packer #(
        .ENC_BYTES (ENC_BYTES),
        .OUT_BYTES (OUT_BYTES),
        .BUF_BYTES (BUF_BYTES)
    ) u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .app_en_i     (fire_s),
        .app_last_i   (last_s),
        .app_data_i   (enc_data_out),
        .app_len_i    (enc_len_bytes),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_be       (out_be),
        .out_eom      (out_eom),
        .count_o      (count_s),
        .space_ok_o   (space_ok_s),
        .mark_valid_o (mark_valid_s),
        .pop_eom_o    (pop_eom_s)
    );

    dfd_te_msg_sched_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .MDO_BITS   (MDO_BITS),
        .ENC_BYTES  (ENC_BYTES),
        .OUT_BYTES  (OUT_BYTES),
        .BUF_BYTES  (BUF_BYTES)
    ) u_chk (
        .clk           (clk),
        .reset_n       (reset_n),
        .count         (count_s),
        .enc_len_bytes (enc_len_bytes),
        .out_be        (out_be),
        .state         (state_q),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready)
    );

endmodule
